// File: rtl/mult_ctrl_pkg.sv
// Shared constants and state encoding for shared-core multiplier controllers.
// Operand and result widths match the 8x8 shift-add core.
package mult_ctrl_pkg;

   localparam int OP_W  = 8;
   localparam int RES_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_RUN       = 3'd3,
      ST_RESP      = 3'd4
   } state_t;

endpackage

// File: rtl/mult_arbiter_if.sv
// Client-side bundle: per-requester operand requests plus the tagged product response.
// master = client side, slave = arbiter side.
interface mult_arbiter_if
   import mult_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = 2
);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [OP_W*NREQ-1:0] req_a;
   logic [OP_W*NREQ-1:0] req_b;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [RES_W-1:0]     rsp_y;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_y
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_y
   );

endinterface

// File: rtl/mult_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after rr_ptr wins.
// Usable by any shared-core controller that keeps its own pointer.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_idx,
   output logic            any_grant
);

   // Scan from the farthest offset down so the nearest requester to rr_ptr is the last, winning write.
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      any_grant = 1'b0;
      idx       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = (int'(rr_ptr) + k) % NREQ;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
            any_grant  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one sequential 8x8 multiplier core between NREQ requesters: round-robin grant,
// operand latch, init pulse, busy tracking and a tagged valid/ready product response.
module mult_arbiter
   import mult_ctrl_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   mult_arbiter_if.slave    bus,
   output logic [OP_W-1:0]  mult_a,
   output logic [OP_W-1:0]  mult_b,
   output logic             mult_init,
   input  logic             mult_busy,
   input  logic [RES_W-1:0] mult_y
);

   state_t          state;
   logic [ID_W-1:0] rr_ptr;
   logic [ID_W-1:0] id;
   logic [NREQ-1:0] grant;
   logic [ID_W-1:0] grant_idx;
   logic            any_grant;
   logic            handshake;

   rr_arbiter #(
      .NREQ(NREQ),
      .ID_W(ID_W)
   ) u_rr_arbiter (
      .req       (bus.req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_grant (any_grant)
   );

   // Ready is only offered while idle, so at most one multiply is ever in flight.
   assign bus.req_ready = (state == ST_IDLE) ? grant : '0;
   assign handshake     = (state == ST_IDLE) && any_grant;

   // Controller FSM; mult_init is registered so it is high exactly during START.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= ST_IDLE;
         rr_ptr        <= '0;
         id            <= '0;
         mult_a        <= '0;
         mult_b        <= '0;
         mult_init     <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_y     <= '0;
      end else begin
         mult_init <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (handshake) begin
                  mult_a    <= bus.req_a[int'(grant_idx)*OP_W +: OP_W];
                  mult_b    <= bus.req_b[int'(grant_idx)*OP_W +: OP_W];
                  id        <= grant_idx;
                  rr_ptr    <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                  mult_init <= 1'b1;
                  state     <= ST_START;
               end
            end
            ST_START: begin
               state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (mult_busy) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (!mult_busy) begin
                  bus.rsp_y     <= mult_y;
                  bus.rsp_id    <= id;
                  bus.rsp_valid <= 1'b1;
                  state         <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  bus.rsp_valid <= 1'b0;
                  state         <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter with a behavioural multiplier core and a
// round-robin reference model; table vectors, hand sequences and random transactions.
module tb_mult_arbiter;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] a;
      logic [31:0] b;
      int          exp_id;
      logic [15:0] exp_y;
      int          hold;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  mult_a;
   logic [7:0]  mult_b;
   logic        mult_init;
   logic        mult_busy;
   logic [15:0] mult_y;

   int total = 0;
   int bad = 0;
   int model_ptr = 0;
   int core_lat = 3;
   int core_cnt;

   mult_arbiter_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

   mult_arbiter #(
      .NREQ(NREQ),
      .ID_W(ID_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .mult_a    (mult_a),
      .mult_b    (mult_b),
      .mult_init (mult_init),
      .mult_busy (mult_busy),
      .mult_y    (mult_y)
   );

   always #5 clk = ~clk;

   // Behavioural core: busy for core_lat cycles after init, product taken from the live operands.
   always @(posedge clk) begin
      if (reset) begin
         mult_busy <= 1'b0;
         core_cnt  <= 0;
         mult_y    <= '0;
      end else if (mult_init) begin
         mult_busy <= 1'b1;
         core_cnt  <= core_lat;
      end else if (mult_busy) begin
         if (core_cnt <= 1) begin
            mult_busy <= 1'b0;
            mult_y    <= 16'(mult_a) * 16'(mult_b);
         end else begin
            core_cnt <= core_cnt - 1;
         end
      end
   end

   function automatic logic [7:0] lane(input logic [31:0] v, input int i);
      return v[8*i +: 8];
   endfunction

   function automatic int modelGrant(input logic [3:0] v, input int ptr);
      for (int step = 0; step < NREQ; step++) begin
         if (v[(ptr + step) % NREQ]) return (ptr + step) % NREQ;
      end
      return -1;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One full transaction from IDLE back to IDLE; hold>0 keeps rsp_ready low that many cycles.
   task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] a, input logic [31:0] b,
                                input int exp_id, input logic [15:0] exp_y, input int hold);
      int cycles;
      bit seen;
      @(negedge clk);
      core_lat      = int'($urandom_range(1, 6));
      bus.req_valid = valid;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.rsp_ready = (hold == 0);
      #1;
      checkOutput("req_ready_grant", 32'(bus.req_ready), 32'(1) << exp_id);
      @(negedge clk);
      checkOutput("mult_init_pulse", 32'(mult_init), 32'd1);
      checkOutput("mult_a_latch", 32'(mult_a), 32'(lane(a, exp_id)));
      checkOutput("mult_b_latch", 32'(mult_b), 32'(lane(b, exp_id)));
      bus.req_a = $urandom;
      bus.req_b = $urandom;
      cycles = 0;
      seen   = 1'b0;
      while (!seen && cycles < 60) begin
         @(negedge clk);
         cycles++;
         if (bus.rsp_valid) begin
            seen = 1'b1;
         end else begin
            checkOutput("busy_req_ready", 32'(bus.req_ready), 32'd0);
            checkOutput("busy_mult_init", 32'(mult_init), 32'd0);
            checkOutput("busy_mult_a", 32'(mult_a), 32'(lane(a, exp_id)));
         end
      end
      checkOutput("rsp_seen", 32'(seen), 32'd1);
      checkOutput("rsp_y", 32'(bus.rsp_y), 32'(exp_y));
      checkOutput("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         checkOutput("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         checkOutput("hold_rsp_y", 32'(bus.rsp_y), 32'(exp_y));
         checkOutput("hold_rsp_id", 32'(bus.rsp_id), 32'(exp_id));
         checkOutput("hold_req_ready", 32'(bus.req_ready), 32'd0);
         checkOutput("hold_mult_init", 32'(mult_init), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      checkOutput("rsp_consumed", 32'(bus.rsp_valid), 32'd0);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;
      model_ptr = (exp_id + 1) % NREQ;
   endtask

   initial begin
      vec_t vecs[7];
      logic [3:0]  v;
      logic [31:0] ra;
      logic [31:0] rb;
      int          e;

      vecs[0] = '{4'b0001, 32'h0000000D, 32'h0000000B, 0, 16'h008F, 0};
      vecs[1] = '{4'b0100, 32'h00FF0000, 32'h00FF0000, 2, 16'hFE01, 10};
      vecs[2] = '{4'b0001, 32'h00000000, 32'h000000C8, 0, 16'h0000, 0};
      vecs[3] = '{4'b1001, 32'h14000001, 32'h0A000001, 3, 16'h00C8, 1};
      vecs[4] = '{4'b1010, 32'h02001000, 32'h02001000, 1, 16'h0100, 0};
      vecs[5] = '{4'b0011, 32'h00000380, 32'h00000302, 0, 16'h0100, 2};
      vecs[6] = '{4'b1000, 32'hFF000000, 32'h01000000, 3, 16'h00FF, 0};

      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("reset_rsp_y", 32'(bus.rsp_y), 32'd0);
      checkOutput("reset_mult_init", 32'(mult_init), 32'd0);
      checkOutput("reset_mult_a", 32'(mult_a), 32'd0);
      checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].exp_id, vecs[i].exp_y, vecs[i].hold);
      end

      // Requester 1 withdraws before any edge; grant moves to requester 2 and nothing is lost.
      @(negedge clk);
      bus.req_valid = 4'b0110;
      #1;
      checkOutput("drop_grant_first", 32'(bus.req_ready), 32'h2);
      bus.req_valid = 4'b0100;
      #1;
      checkOutput("drop_grant_after", 32'(bus.req_ready), 32'h4);
      bus.req_valid = 4'b0000;
      @(negedge clk);
      checkOutput("idle_no_ready", 32'(bus.req_ready), 32'd0);
      applyStimulus(4'b0100, 32'h00050000, 32'h00090000, 2, 16'h002D, 0);

      // Reset while the core is busy: everything returns to reset values, pointer back to 0.
      @(negedge clk);
      core_lat      = 6;
      bus.req_valid = 4'b0010;
      bus.req_a     = 32'h00000900;
      bus.req_b     = 32'h00000900;
      #1;
      checkOutput("mid_run_grant", 32'(bus.req_ready), 32'h2);
      repeat (4) @(negedge clk);
      bus.req_valid = '0;
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      checkOutput("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
      checkOutput("rst_rsp_y", 32'(bus.rsp_y), 32'd0);
      checkOutput("rst_mult_init", 32'(mult_init), 32'd0);
      checkOutput("rst_mult_a", 32'(mult_a), 32'd0);
      checkOutput("rst_mult_b", 32'(mult_b), 32'd0);
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      reset = 1'b0;
      model_ptr = 0;
      repeat (2) @(negedge clk);
      checkOutput("rst_no_stale_rsp", 32'(bus.rsp_valid), 32'd0);
      applyStimulus(4'b1111, 32'h07070707, 32'h06060606, 0, 16'h002A, 0);

      for (int n = 0; n < 30; n++) begin
         v  = 4'($urandom_range(1, 15));
         ra = $urandom;
         rb = $urandom;
         e  = modelGrant(v, model_ptr);
         applyStimulus(v, ra, rb, e, 16'(lane(ra, e)) * 16'(lane(rb, e)), int'($urandom_range(0, 3)));
      end

      for (int n = 0; n < 8; n++) begin
         ra = $urandom;
         rb = $urandom;
         e  = modelGrant(4'hF, model_ptr);
         applyStimulus(4'hF, ra, rb, e, 16'(lane(ra, e)) * 16'(lane(rb, e)), 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
